jtframe_pocket_vrx: RTL and testbench

- Receiver for the Pocket video interface: takes 24-bit RGB, pixel clock, DE and single-pixel HS/VS pulses; recovers base-style video (pixel enable, LHBL/LVBL, stretched HS/VS, COLORW-bit RGB).
- Measures total and active frame geometry and reports lock status.
- Used in loop-back simulation benches and by the scaler/debug capture path, which consume the Pocket output stream inside the same clk domain.

---
 rtl/jtframe_pocket_vrx.sv | 170 +++++++++++++++++
 tb/tb_jtframe_pocket_vrx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_pocket_vrx.sv
// Pocket video receiver: recovers pixel enable, blanking, stretched syncs
// and truncated RGB from the Pocket stream, and measures frame geometry.
module jtframe_pocket_vrx #(
  parameter int COLORW = 4,
  parameter int CW     = 12,
  parameter int HSW    = 8,
  parameter int VSW    = 3,
  parameter int TOUT   = 1023
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [23:0]         pck_rgb,
  input  logic                pck_rgb_clk,
  input  logic                pck_de,
  input  logic                pck_hs,
  input  logic                pck_vs,
  input  logic                pck_skip,
  output logic                pxl_cen,
  output logic [3*COLORW-1:0] rgb,
  output logic                lhbl,
  output logic                lvbl,
  output logic                hs,
  output logic                vs,
  output logic [CW-1:0]       htotal,
  output logic [CW-1:0]       hact,
  output logic [CW-1:0]       vtotal,
  output logic [CW-1:0]       vact,
  output logic                locked
);

  localparam int TW  = $clog2(TOUT+1);
  localparam int HCW = $clog2(HSW+1);
  localparam int VCW = $clog2(VSW+1);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] SYNC1  = 2'd1;
  localparam logic [1:0] LOCK   = 2'd2;

  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic                rclk;
  logic                rclk_l;
  logic                strobe;
  logic                take;
  logic                timeout;
  logic [1:0]          state;
  logic [CW-1:0]       hcnt;
  logic [CW-1:0]       hdcnt;
  logic [CW-1:0]       vcnt;
  logic [CW-1:0]       vdcnt;
  logic [CW-1:0]       hcnt_n;
  logic [CW-1:0]       hdcnt_n;
  logic [CW-1:0]       vcnt_n;
  logic [CW-1:0]       vdcnt_n;
  logic [CW-1:0]       ht_n;
  logic                line_de;
  logic                line_act;
  logic [HCW-1:0]      hscnt;
  logic [VCW-1:0]      vscnt;
  logic [TW-1:0]       wd;
  logic [3*COLORW-1:0] rgb_in;
  logic                unused_rgb;

  // falling edge of the pixel clock lands mid-pixel, where data is stable
  assign strobe  = rclk_l & ~rclk;
  assign take    = strobe & ~pck_skip;
  assign timeout = wd == TW'(TOUT);
  assign locked  = state == LOCK;

  assign rgb_in = {pck_rgb[23 -: COLORW],
                   pck_rgb[15 -: COLORW],
                   pck_rgb[7 -: COLORW]};
  assign unused_rgb = ^pck_rgb;

  always_comb begin
    hcnt_n   = hcnt == CMAX ? hcnt : hcnt + CW'(1);
    hdcnt_n  = pck_de && hdcnt != CMAX ?
               hdcnt + CW'(1) : hdcnt;
    line_act = line_de | pck_de;
    vcnt_n   = pck_hs && vcnt != CMAX ?
               vcnt + CW'(1) : vcnt;
    vdcnt_n  = pck_hs && line_act && vdcnt != CMAX ?
               vdcnt + CW'(1) : vdcnt;
    ht_n     = pck_hs ? hcnt_n : htotal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rclk    <= 1'b0;
      rclk_l  <= 1'b0;
      pxl_cen <= 1'b0;
      rgb     <= '0;
      lhbl    <= 1'b0;
      lvbl    <= 1'b0;
      hs      <= 1'b0;
      vs      <= 1'b0;
      htotal  <= '0;
      hact    <= '0;
      vtotal  <= '0;
      vact    <= '0;
      hcnt    <= '0;
      hdcnt   <= '0;
      vcnt    <= '0;
      vdcnt   <= '0;
      line_de <= 1'b0;
      hscnt   <= '0;
      vscnt   <= '0;
      wd      <= '0;
      state   <= SEARCH;
    end else begin
      rclk    <= pck_rgb_clk;
      rclk_l  <= rclk;
      pxl_cen <= take;
      if (strobe) wd <= '0;
      else if (!timeout) wd <= wd + TW'(1);
      if (take) begin
        rgb     <= pck_de ? rgb_in : '0;
        lhbl    <= pck_de;
        hcnt    <= pck_hs ? '0 : hcnt_n;
        hdcnt   <= pck_hs ? '0 : hdcnt_n;
        line_de <= pck_hs ? 1'b0 : line_act;
        vcnt    <= pck_vs ? '0 : vcnt_n;
        vdcnt   <= pck_vs ? '0 : vdcnt_n;
        if (pck_de) lvbl <= 1'b1;
        else if (pck_hs && !line_act) lvbl <= 1'b0;
        if (pck_hs) begin
          htotal <= hcnt_n;
          if (hdcnt_n != '0) hact <= hdcnt_n;
          hs    <= 1'b1;
          hscnt <= HCW'(HSW-1);
        end else if (hscnt != '0) begin
          hscnt <= hscnt - HCW'(1);
        end else begin
          hs <= 1'b0;
        end
        if (pck_vs) begin
          vtotal <= vcnt_n;
          vact   <= vdcnt_n;
          vs     <= 1'b1;
          vscnt  <= VCW'(VSW-1);
          case (state)
            SEARCH: state <= SYNC1;
            SYNC1: begin
              if (ht_n != '0 && vcnt_n != '0 && vdcnt_n != '0)
                state <= LOCK;
            end
            LOCK: begin
              // htotal jitter is tolerated, only vertical changes break lock
              if (vcnt_n != vtotal || vdcnt_n != vact)
                state <= SYNC1;
            end
            default: state <= SEARCH;
          endcase
        end else if (pck_hs) begin
          if (vscnt != '0) vscnt <= vscnt - VCW'(1);
          else vs <= 1'b0;
        end
      end
      if (timeout && !strobe) begin
        state <= SEARCH;
        lhbl  <= 1'b0;
        lvbl  <= 1'b0;
        rgb   <= '0;
        hs    <= 1'b0;
        vs    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_vrx.sv
// Bench for jtframe_pocket_vrx: table vectors, random-pixel frames against
// a line/frame level model, and hand-written lock/timeout/reset sequences.
module tb_jtframe_pocket_vrx;

  localparam int HT  = 32;
  localparam int VT  = 12;
  localparam int H0  = 4;
  localparam int HA  = 24;
  localparam int V0  = 2;
  localparam int VA  = 8;
  localparam int HSW = 8;
  localparam int VSW = 3;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [23:0] pck_rgb = 0;
  logic        pck_rgb_clk = 0;
  logic        pck_de = 0;
  logic        pck_hs = 0;
  logic        pck_vs = 0;
  logic        pck_skip = 0;
  logic        pxl_cen;
  logic [11:0] rgb;
  logic        lhbl;
  logic        lvbl;
  logic        hs;
  logic        vs;
  logic [11:0] htotal;
  logic [11:0] hact;
  logic [11:0] vtotal;
  logic [11:0] vact;
  logic        locked;

  jtframe_pocket_vrx dut (
    .clk(clk), .rst_n(rst_n),
    .pck_rgb(pck_rgb), .pck_rgb_clk(pck_rgb_clk),
    .pck_de(pck_de), .pck_hs(pck_hs), .pck_vs(pck_vs),
    .pck_skip(pck_skip), .pxl_cen(pxl_cen), .rgb(rgb),
    .lhbl(lhbl), .lvbl(lvbl), .hs(hs), .vs(vs),
    .htotal(htotal), .hact(hact), .vtotal(vtotal),
    .vact(vact), .locked(locked)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  int cyc = 0;
  int last_cen = -100;
  int last_gap = 0;
  int cen_cnt = 0;
  int run = 0;
  int max_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (pxl_cen) begin
      run++;
      if (run > max_run) max_run = run;
      if (run == 1) begin
        last_gap = cyc - last_cen;
        last_cen = cyc;
        cen_cnt++;
      end
    end else begin
      run = 0;
    end
  end

  logic [11:0] exp_rgb;
  logic        exp_lhbl;
  logic        exp_lvbl;
  logic        had_de;
  int          k_hs;
  int          ln_vs;
  int          exp_cen = 0;

  task automatic model_reset();
    exp_rgb = 0;
    exp_lhbl = 0;
    exp_lvbl = 0;
    had_de = 0;
    k_hs = HSW;
    ln_vs = VSW;
  endtask

  task automatic model_timeout();
    exp_rgb = 0;
    exp_lhbl = 0;
    exp_lvbl = 0;
    k_hs = HSW;
    ln_vs = VSW;
  endtask

  // one pixel: 4 clk high, 4 clk low; called and returns on a negedge
  task automatic send_px(input logic [23:0] c, input logic de,
                         input logic h, input logic v,
                         input logic skip, input bit check);
    pck_rgb = c;
    pck_de = de;
    pck_hs = h;
    pck_vs = v;
    pck_skip = skip;
    pck_rgb_clk = 1;
    repeat (4) @(negedge clk);
    pck_rgb_clk = 0;
    repeat (4) @(negedge clk);
    if (!skip) begin
      exp_cen++;
      if (h) begin
        if (!had_de && !de) exp_lvbl = 0;
        had_de = 0;
        k_hs = 0;
      end else if (k_hs < HSW) begin
        k_hs++;
      end
      if (v) ln_vs = 0;
      else if (h && ln_vs < VSW) ln_vs++;
      if (de) begin
        exp_lvbl = 1;
        if (!h) had_de = 1;
      end
      exp_rgb = de ? {c[23:20], c[15:12], c[7:4]} : 12'h0;
      exp_lhbl = de;
    end
    if (check) begin
      chk("rgb", rgb, exp_rgb);
      chk("lhbl", lhbl, exp_lhbl);
      chk("lvbl", lvbl, exp_lvbl);
      chk("hs", hs, int'(k_hs < HSW));
      chk("vs", vs, int'(ln_vs < VSW));
    end
  endtask

  task automatic send_frame(input bit drop_vs, input bit skip_odd);
    logic [23:0] c;
    logic        de;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        c = 24'($urandom);
        de = x >= H0 && x < H0 + HA && y >= V0 && y < V0 + VA;
        send_px(c, de, x == 0, x == 0 && y == 0 && !drop_vs,
                skip_odd && (x % 2 == 1), 1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pxl_cen"}, pxl_cen, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_lhbl"}, lhbl, 0);
    chk({tag, "_lvbl"}, lvbl, 0);
    chk({tag, "_hs"}, hs, 0);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_htotal"}, htotal, 0);
    chk({tag, "_hact"}, hact, 0);
    chk({tag, "_vtotal"}, vtotal, 0);
    chk({tag, "_vact"}, vact, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  typedef struct {
    logic [23:0] c;
    logic        de;
    logic [11:0] rgb;
    logic        lhbl;
  } vec_t;

  vec_t tv[7];
  int   c0;

  initial begin
    tv[0] = '{24'hA53CF0, 1'b1, 12'hA3F, 1'b1};
    tv[1] = '{24'hA53CF0, 1'b0, 12'h000, 1'b0};
    tv[2] = '{24'hFFFFFF, 1'b1, 12'hFFF, 1'b1};
    tv[3] = '{24'h000000, 1'b1, 12'h000, 1'b1};
    tv[4] = '{24'h123456, 1'b1, 12'h135, 1'b1};
    tv[5] = '{24'h808080, 1'b1, 12'h888, 1'b1};
    tv[6] = '{24'h7F7F7F, 1'b0, 12'h000, 1'b0};

    model_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;

    for (int i = 0; i < 7; i++) begin
      send_px(tv[i].c, tv[i].de, 0, 0, 0, 0);
      chk($sformatf("tv%0d_rgb", i), rgb, tv[i].rgb);
      chk($sformatf("tv%0d_lhbl", i), lhbl, tv[i].lhbl);
    end

    send_frame(0, 0);
    chk("sync1_locked", locked, 0);
    send_frame(0, 0);
    chk("lock_htotal", htotal, HT);
    chk("lock_hact", hact, HA);
    chk("lock_vtotal", vtotal, VT);
    chk("lock_vact", vact, VA);
    chk("lock_locked", locked, 1);
    chk("cen_period", last_gap, 8);
    chk("cen_width", max_run, 1);
    chk("cen_count", cen_cnt, exp_cen);

    send_frame(0, 0);
    chk("steady_locked", locked, 1);
    send_frame(1, 0);
    chk("novs_locked", locked, 1);
    send_frame(0, 0);
    chk("resume_locked", locked, 0);
    chk("resume_vtotal", vtotal, 2 * VT);
    chk("resume_vact", vact, 2 * VA);
    send_frame(0, 0);
    chk("relock_locked", locked, 1);
    chk("relock_vtotal", vtotal, VT);

    repeat (1000) @(negedge clk);
    chk("pre_tout_locked", locked, 1);
    repeat (28) @(negedge clk);
    chk("tout_locked", locked, 0);
    chk("tout_lhbl", lhbl, 0);
    chk("tout_lvbl", lvbl, 0);
    chk("tout_hs", hs, 0);
    chk("tout_vs", vs, 0);
    chk("tout_rgb", rgb, 0);
    chk("tout_htotal", htotal, HT);
    chk("tout_vtotal", vtotal, VT);
    repeat (72) @(negedge clk);
    model_timeout();
    chk("tout_hold_locked", locked, 0);
    send_frame(0, 0);
    chk("tout_sync1", locked, 0);
    send_frame(0, 0);
    chk("tout_relock", locked, 1);

    for (int x = 0; x < 10; x++)
      send_px(24'($urandom), 0, x == 0, x == 0, 0, 1);
    rst_n = 0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1;
    model_reset();
    send_frame(0, 0);
    chk("rst_sync1", locked, 0);
    send_frame(0, 0);
    chk("rst_relock", locked, 1);
    chk("rst_vtotal", vtotal, VT);

    c0 = cen_cnt;
    send_frame(0, 1);
    chk("skip_cen_count", cen_cnt - c0, HT * VT / 2);
    send_frame(0, 1);
    chk("skip_htotal", htotal, HT / 2);
    chk("skip_hact", hact, HA / 2);
    chk("skip_vtotal", vtotal, VT);
    chk("skip_vact", vact, VA);
    chk("skip_locked", locked, 1);
    chk("final_cen_count", cen_cnt, exp_cen);
    chk("final_cen_width", max_run, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
